// File: rtl/hwpe_dma_loader_pkg.sv
// hwpe_dma_loader_pkg
//   Shared definitions for the hwpe DMA loader: SRAM address width, the
//   fmap/kernel region start addresses, the default read-outstanding limit
//   and the loader FSM state type.
package hwpe_dma_loader_pkg;

   localparam int HWPE_ADDR_WIDTH  = 16;
   localparam int HWPE_DMA_MAX_OUT = 2;

   localparam logic [HWPE_ADDR_WIDTH-1:0] FMEM_ADDR2_START = 16'h4000;
   localparam logic [HWPE_ADDR_WIDTH-1:0] KMEM_ADDR_START  = 16'h8000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_t;

endpackage

// File: rtl/hwpe_dma_pack.sv
// hwpe_dma_pack
//   Packs pairs of 32-bit read words into 64-bit hwpe SRAM writes. The
//   first word of a pair lands in dma_wd[31:0], the second in dma_wd[63:32].
//   Write-port outputs are registered; dma_wen pulses for one cycle after
//   the high-word arrives.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clear          restart packing and load the destination address
//   load_addr      first write address, taken on clear
//   word_valid     a read word is arriving this cycle
//   word           the read word
//   suppress       drop the write a high word would otherwise produce
//   dma_wen/wa/wd  hwpe SRAM write port
module hwpe_dma_pack
   import hwpe_dma_loader_pkg::*;
#(
   parameter int ADDR_W = HWPE_ADDR_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              word_valid,
   input  logic [31:0]       word,
   input  logic              suppress,
   output logic              dma_wen,
   output logic [ADDR_W-1:0] dma_wa,
   output logic [63:0]       dma_wd
);

   logic              hi_q;
   logic [31:0]       lo_q;
   logic [ADDR_W-1:0] dst_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q    <= 1'b0;
         lo_q    <= '0;
         dst_q   <= '0;
         dma_wen <= 1'b0;
         dma_wa  <= '0;
         dma_wd  <= '0;
      end else begin
         dma_wen <= 1'b0;
         if (clear) begin
            hi_q  <= 1'b0;
            lo_q  <= '0;
            dst_q <= load_addr;
         end else if (word_valid) begin
            hi_q <= ~hi_q;
            if (!hi_q) begin
               lo_q <= word;
            end else begin
               // Destination advances even for a dropped beat; the
               // transfer is being abandoned in that case anyway.
               dst_q <= dst_q + ADDR_W'(8);
               if (!suppress) begin
                  dma_wen <= 1'b1;
                  dma_wa  <= dst_q;
                  dma_wd  <= {word, lo_q};
               end
            end
         end
      end
   end

endmodule

// File: rtl/hwpe_dma_loader.sv
// hwpe_dma_loader
//   DMA engine feeding the hwpe SRAM write port. Accepts a copy descriptor,
//   reads 2*beats 32-bit words over an ICB master port (in-order responses,
//   up to MAX_OUT outstanding) and writes them as 64-bit beats.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   desc_valid/ready           descriptor handshake
//   desc_src/dst/beats         ICB byte source, SRAM byte dest, beat count
//   icb_cmd_*                  ICB read command channel (read tied high)
//   icb_rsp_*                  ICB read response channel (ready tied high)
//   dma_wen/wa/wd              hwpe SRAM write port
//   done, err                  completion pulse and its error status
// Configuration:
//   HWPE_DMA_ERR_ABORT_EN      when defined, the first error response stops
//                              issue and drops all further writes; otherwise
//                              errors only set the sticky err status.
module hwpe_dma_loader
   import hwpe_dma_loader_pkg::*;
#(
   parameter int ADDR_W  = HWPE_ADDR_WIDTH,
   parameter int BEATS_W = 16,
   parameter int MAX_OUT = HWPE_DMA_MAX_OUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               desc_valid,
   output logic               desc_ready,
   input  logic [31:0]        desc_src,
   input  logic [ADDR_W-1:0]  desc_dst,
   input  logic [BEATS_W-1:0] desc_beats,
   output logic               icb_cmd_valid,
   input  logic               icb_cmd_ready,
   output logic [31:0]        icb_cmd_addr,
   output logic               icb_cmd_read,
   input  logic               icb_rsp_valid,
   output logic               icb_rsp_ready,
   input  logic [31:0]        icb_rsp_rdata,
   input  logic               icb_rsp_err,
   output logic               dma_wen,
   output logic [ADDR_W-1:0]  dma_wa,
   output logic [63:0]        dma_wd,
   output logic               done,
   output logic               err
);

`ifdef HWPE_DMA_ERR_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   dma_state_t       state;
   logic [31:0]      src_q;
   logic [BEATS_W:0] words_left;
   logic [2:0]       outstanding;
   logic             err_q;
   logic             abort_q;

   logic accept;
   logic busy;
   logic cmd_hs;
   logic rsp_dec;
   logic rsp_err_now;
   logic suppress;

   // Source address bits [1:0] are forced to zero on accept.
   logic unused_src_lsb;
   assign unused_src_lsb = ^desc_src[1:0];

   assign icb_cmd_read  = 1'b1;
   assign icb_rsp_ready = 1'b1;
   assign icb_cmd_addr  = src_q;
   // Driven only from registers, so the address and valid stay put until
   // the handshake completes.
   assign icb_cmd_valid = (state == ST_RUN) && (words_left != '0) &&
                          (outstanding < 3'(MAX_OUT)) && !abort_q;

   assign accept      = desc_valid && desc_ready;
   assign busy        = (state != ST_IDLE);
   assign cmd_hs      = icb_cmd_valid && icb_cmd_ready;
   assign rsp_dec     = icb_rsp_valid && (outstanding != '0);
   assign rsp_err_now = icb_rsp_valid && icb_rsp_err && busy;
   // The erroring word itself is already dropped in abort mode.
   assign suppress    = ABORT_EN && (abort_q || rsp_err_now);

   hwpe_dma_pack #(
      .ADDR_W(ADDR_W)
   ) u_pack (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (accept),
      .load_addr  (desc_dst),
      .word_valid (icb_rsp_valid && busy),
      .word       (icb_rsp_rdata),
      .suppress   (suppress),
      .dma_wen    (dma_wen),
      .dma_wa     (dma_wa),
      .dma_wd     (dma_wd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         desc_ready  <= 1'b0;
         src_q       <= '0;
         words_left  <= '0;
         outstanding <= '0;
         err_q       <= 1'b0;
         abort_q     <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         if (cmd_hs) begin
            src_q      <= src_q + 32'd4;
            words_left <= words_left - (BEATS_W+1)'(1);
         end

         if (cmd_hs && !rsp_dec) begin
            outstanding <= outstanding + 3'd1;
         end else if (!cmd_hs && rsp_dec) begin
            outstanding <= outstanding - 3'd1;
         end

         if (rsp_err_now) begin
            err_q <= 1'b1;
            if (ABORT_EN) begin
               abort_q <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               desc_ready <= 1'b1;
               if (accept) begin
                  desc_ready <= 1'b0;
                  src_q      <= {desc_src[31:2], 2'b00};
                  words_left <= {desc_beats, 1'b0};
                  err_q      <= 1'b0;
                  abort_q    <= 1'b0;
                  state      <= (desc_beats == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if ((words_left == '0) || abort_q) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if ((outstanding == '0) && !icb_rsp_valid) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done       <= 1'b1;
               err        <= err_q;
               desc_ready <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// tb_hwpe_dma_loader
//   Directed bench for hwpe_dma_loader: an ICB read responder backed by a
//   synthetic memory, a write checker fed from an expected-write queue, and
//   directed descriptor sequences.
module tb_hwpe_dma_loader;
   import hwpe_dma_loader_pkg::*;

   localparam int AW = HWPE_ADDR_WIDTH;
   localparam int BW = 16;
   localparam int MO = 2;

   logic          clk;
   logic          rst_n;
   logic          desc_valid;
   logic          desc_ready;
   logic [31:0]   desc_src;
   logic [AW-1:0] desc_dst;
   logic [BW-1:0] desc_beats;
   logic          icb_cmd_valid;
   logic          icb_cmd_ready;
   logic [31:0]   icb_cmd_addr;
   logic          icb_cmd_read;
   logic          icb_rsp_valid;
   logic          icb_rsp_ready;
   logic [31:0]   icb_rsp_rdata;
   logic          icb_rsp_err;
   logic          dma_wen;
   logic [AW-1:0] dma_wa;
   logic [63:0]   dma_wd;
   logic          done;
   logic          err;

   hwpe_dma_loader #(
      .ADDR_W  (AW),
      .BEATS_W (BW),
      .MAX_OUT (MO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .desc_valid    (desc_valid),
      .desc_ready    (desc_ready),
      .desc_src      (desc_src),
      .desc_dst      (desc_dst),
      .desc_beats    (desc_beats),
      .icb_cmd_valid (icb_cmd_valid),
      .icb_cmd_ready (icb_cmd_ready),
      .icb_cmd_addr  (icb_cmd_addr),
      .icb_cmd_read  (icb_cmd_read),
      .icb_rsp_valid (icb_rsp_valid),
      .icb_rsp_ready (icb_rsp_ready),
      .icb_rsp_rdata (icb_rsp_rdata),
      .icb_rsp_err   (icb_rsp_err),
      .dma_wen       (dma_wen),
      .dma_wa        (dma_wa),
      .dma_wd        (dma_wd),
      .done          (done),
      .err           (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Byte-ascending pattern, offset by the upper address bits so that
   // different 256-byte pages differ. At 0x100 this yields 0x03020100.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b + 8'd3, b + 8'd2, b + 8'd1, b} ^ {8'h00, a[31:8] - 24'd1};
   endfunction

   typedef struct packed {
      logic [AW-1:0] wa;
      logic [63:0]   wd;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] pend_q[$];

   bit            stall_en   = 1'b0;
   bit            rsp_hold   = 1'b0;
   int            err_idx    = -1;
   int            rsp_idx    = 0;
   int            wr_cnt     = 0;
   int            wr_bad     = 0;
   int            cmd_cnt    = 0;
   int            done_cnt   = 0;
   int            consec_bad = 0;
   int            stab_bad   = 0;
   int            outs       = 0;
   int            max_outs   = 0;
   logic          last_err   = 1'b0;
   logic [AW-1:0] last_wa    = '0;
   logic [63:0]   last_wd    = '0;
   logic          prev_stall = 1'b0;
   logic          prev_wen   = 1'b0;
   logic [31:0]   prev_addr  = '0;
   logic          acc_done   = 1'b0;
   wr_t           e;
   logic [31:0]   ra;

   // Monitor and ICB responder: observe at the falling edge, then set up
   // the inputs for the next rising edge.
   initial begin
      icb_cmd_ready = 1'b0;
      icb_rsp_valid = 1'b0;
      icb_rsp_rdata = '0;
      icb_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (dma_wen) begin
            wr_cnt++;
            last_wa = dma_wa;
            last_wd = dma_wd;
            if (exp_q.size() == 0) begin
               wr_bad++;
            end else begin
               e = exp_q.pop_front();
               if (e.wa !== dma_wa || e.wd !== dma_wd) wr_bad++;
            end
         end
         if (dma_wen && prev_wen) consec_bad++;
         prev_wen = dma_wen;
         if (done) begin
            done_cnt++;
            last_err = err;
         end
         if (prev_stall && (!icb_cmd_valid || icb_cmd_addr !== prev_addr)) stab_bad++;

         if (!rsp_hold && pend_q.size() > 0 && !(stall_en && $urandom_range(0, 3) == 0)) begin
            ra            = pend_q.pop_front();
            icb_rsp_valid = 1'b1;
            icb_rsp_rdata = mem_word(ra);
            icb_rsp_err   = (rsp_idx == err_idx);
            rsp_idx++;
            outs--;
         end else begin
            icb_rsp_valid = 1'b0;
            icb_rsp_rdata = '0;
            icb_rsp_err   = 1'b0;
         end
         icb_cmd_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (icb_cmd_valid && icb_cmd_ready) begin
            pend_q.push_back(icb_cmd_addr);
            if (rst_n) cmd_cnt++;
            outs++;
         end
         if (outs > max_outs) max_outs = outs;
         prev_stall = rst_n && icb_cmd_valid && !icb_cmd_ready;
         prev_addr  = icb_cmd_addr;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_exp(input logic [31:0] src, input logic [AW-1:0] dst, input int nwr);
      wr_t w;
      for (int i = 0; i < nwr; i++) begin
         w.wa = dst + AW'(8 * i);
         w.wd = {mem_word(src + 32'(8 * i + 4)), mem_word(src + 32'(8 * i))};
         exp_q.push_back(w);
      end
   endtask

   task automatic offer(input logic [31:0] src, input logic [AW-1:0] dst, input logic [BW-1:0] beats);
      desc_valid = 1'b1;
      desc_src   = src;
      desc_dst   = dst;
      desc_beats = beats;
   endtask

   task automatic wait_accept(input string tag);
      int k;
      k = 0;
      while (!desc_ready && k < 5000) begin
         step(1);
         k++;
      end
      if (k >= 5000) check({tag, "_accept_timeout"}, 1, 0);
      acc_done = done;
      step(1);
      desc_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int target);
      int k;
      k = 0;
      while (done_cnt < target && k < 5000) begin
         step(1);
         k++;
      end
      if (k >= 5000) check({tag, "_done_timeout"}, 1, 0);
      step(2);
   endtask

   int d0;
   int nexp_err;

   initial begin
      rst_n      = 1'b0;
      desc_valid = 1'b0;
      desc_src   = '0;
      desc_dst   = '0;
      desc_beats = '0;

      // Reset values
      step(3);
      check("rst_desc_ready", desc_ready, 0);
      check("rst_cmd_valid", icb_cmd_valid, 0);
      check("rst_wen", dma_wen, 0);
      check("rst_wa_wd", {dma_wa, dma_wd[47:0]}, 0);
      check("rst_done_err", {done, err}, 0);
      check("cmd_read_tie", icb_cmd_read, 1);
      check("rsp_ready_tie", icb_rsp_ready, 1);
      rst_n = 1'b1;
      step(1);
      check("post_rst_desc_ready", desc_ready, 1);

      // Single beat, zero-wait ICB
      cmd_cnt = 0;
      wr_cnt  = 0;
      d0      = done_cnt;
      push_exp(32'h100, '0, 1);
      offer(32'h0000_0102, '0, 16'd1);
      wait_accept("single");
      check("single_cmd_valid_next", icb_cmd_valid, 1);
      check("single_cmd_addr", icb_cmd_addr, 32'h100);
      wait_done("single", d0 + 1);
      check("single_wr_cnt", wr_cnt, 1);
      check("single_wa", last_wa, 0);
      check("single_wd", last_wd, 64'h0706050403020100);
      check("single_err", last_err, 0);
      check("single_cmd_cnt", cmd_cnt, 2);

      // Zero length
      cmd_cnt = 0;
      wr_cnt  = 0;
      offer(32'h300, 16'h0010, 16'd0);
      wait_accept("zero");
      check("zero_done_early", done, 0);
      step(1);
      check("zero_done", done, 1);
      check("zero_err", err, 0);
      step(1);
      check("zero_done_pulse", done, 0);
      step(3);
      check("zero_cmd_cnt", cmd_cnt, 0);
      check("zero_wr_cnt", wr_cnt, 0);

      // Error on the third word of a 4-beat descriptor
      wr_cnt  = 0;
      rsp_idx = 0;
      err_idx = 2;
      d0      = done_cnt;
`ifdef HWPE_DMA_ERR_ABORT_EN
      nexp_err = 1;
`else
      nexp_err = 4;
`endif
      push_exp(32'h400, 16'h0100, nexp_err);
      offer(32'h400, 16'h0100, 16'd4);
      wait_accept("errw");
      wait_done("errw", d0 + 1);
      check("errw_wr_cnt", wr_cnt, nexp_err);
      check("errw_err", last_err, 1);
      check("errw_exp_left", exp_q.size(), 0);
      err_idx = -1;

      // Reset after the second write, pending responses arrive afterwards
      wr_cnt = 0;
      push_exp(32'h500, 16'h0200, 8);
      offer(32'h500, 16'h0200, 16'd8);
      wait_accept("rstm");
      for (int k = 0; k < 200 && wr_cnt < 2; k++) step(1);
      check("rstm_two_writes", wr_cnt, 2);
      rsp_hold = 1'b1;
      rst_n    = 1'b0;
      step(3);
      exp_q.delete();
      rst_n    = 1'b1;
      outs     = 0;
      wr_cnt   = 0;
      d0       = done_cnt;
      rsp_hold = 1'b0;
      step(20);
      check("rstm_no_write", wr_cnt, 0);
      check("rstm_no_done", done_cnt - d0, 0);
      outs = 0;
      d0   = done_cnt;
      push_exp(32'h600, 16'h0300, 3);
      offer(32'h600, 16'h0300, 16'd3);
      wait_accept("rstm_new");
      wait_done("rstm_new", d0 + 1);
      check("rstm_new_wr_cnt", wr_cnt, 3);
      check("rstm_new_err", last_err, 0);

      // fmap then kernel back-to-back under random ICB stalls
      stall_en   = 1'b1;
      wr_cnt     = 0;
      max_outs   = 0;
      stab_bad   = 0;
      consec_bad = 0;
      d0         = done_cnt;
      push_exp(32'h1000, FMEM_ADDR2_START, 27);
      push_exp(32'h2000, KMEM_ADDR_START, 128);
      offer(32'h1000, FMEM_ADDR2_START, 16'd27);
      wait_accept("fmap");
      offer(32'h2000, KMEM_ADDR_START, 16'd128);
      wait_accept("kern");
      check("b2b_accept_at_done", acc_done, 1);
      check("b2b_fmap_done", done_cnt - d0, 1);
      wait_done("kern", d0 + 2);
      check("b2b_wr_cnt", wr_cnt, 155);
      check("b2b_exp_left", exp_q.size(), 0);
      check("b2b_max_outs_ok", (max_outs <= MO), 1);
      check("b2b_addr_stable", stab_bad, 0);
      check("b2b_no_consec_wen", consec_bad, 0);
      check("b2b_err", last_err, 0);
      check("write_data_all", wr_bad, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
